axil_ram_mp: RTL and testbench
==============================

AXIL_RAM_MP -- requirements
Module: axil_ram_mp

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of AXI-lite slave ports sharing one RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits (32 or 64).
REQ-003 SHALL have parameter ADDR_W, default 16, byte-address width per port.
REQ-004 SHALL have parameter DEPTH, default 4096, RAM depth in DATA_W words.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports s_awaddr/s_araddr, input, N_PORTS*ADDR_W, per-port write/read address (port p at slice p).
REQ-008 SHALL have ports s_awvalid/s_wvalid/s_arvalid/s_bready/s_rready, input, N_PORTS each, per-port handshake inputs.
REQ-009 SHALL have ports s_wdata (input, N_PORTS*DATA_W) and s_wstrb (input, N_PORTS*DATA_W/8), write data and byte enables.
REQ-010 SHALL have ports s_awready/s_wready/s_arready/s_bvalid/s_rvalid, output, N_PORTS each, per-port handshake outputs.
REQ-011 SHALL have ports s_rdata (output, N_PORTS*DATA_W) and s_bresp/s_rresp (output, N_PORTS*2), read data and responses.

Function
REQ-012 Port p requests when (s_awvalid[p] & s_wvalid[p]) or s_arvalid[p], and only while its response slot for that direction is empty.
REQ-013 One RAM access per cycle; grant round-robin, search starting at the port after the last granted; no grant to a non-requesting port.
REQ-014 Within a granted port, write SHALL win over read when both pending; the read waits for a later grant.
REQ-015 Granted write: s_awready[p] and s_wready[p] both high in the grant cycle (combinational from grant); AW and W never accepted separately.
REQ-016 Granted read: s_arready[p] high in grant cycle; all readies low for non-granted ports.
REQ-017 Word index = addr[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits ignored.
REQ-018 Write updates only bytes with wstrb set; wstrb all-zero performs no change but still returns a B response.
REQ-019 s_bvalid[p]/s_rvalid[p] SHALL assert the cycle after the grant (latency 1) and hold, with data/resp stable, until the matching ready is high.
REQ-020 Read in same cycle as a write to the same word by another port is impossible (one access/cycle); read after write returns new data.
REQ-021 Response slot frees in the cycle ready&valid; port may be re-granted in that same cycle (back-to-back, 1 access/cycle/port).
REQ-022 Responses OKAY = 2'b00; error response SLVERR = 2'b10 per REQ-027.

Reset
REQ-023 While rst low: all s_*ready, s_bvalid, s_rvalid = 0; s_rdata = 0; s_bresp/s_rresp = 0; round-robin pointer = port N_PORTS-1 (port 0 searched first).
REQ-024 Reset mid-transaction SHALL drop pending responses; no RAM write occurs in a cycle with rst low.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 Outputs leave reset values on the first clk edge after rst deasserts.

Configuration
REQ-027 Macro AXIL_RAM_MP_RANGE_CHECK_EN defined: word index >= DEPTH gives SLVERR, write discarded, rdata = 0.
REQ-028 Macro undefined: word index taken modulo DEPTH (DEPTH power of two required), response always OKAY.

Verification
REQ-029 Port0 write 0xDEADBEEF to 0x0010 strb 0xF, then read 0x0010 -> bvalid cycle+1, rdata 0xDEADBEEF, rresp 00.
REQ-030 Write 0xFFFFFFFF then 0x00000000 strb 0x5 to 0x0020, read -> 0xFF00FF00.
REQ-031 Both ports arvalid continuously, rready=1, 8 cycles -> grants alternate 0,1,0,1..., 4 reads each, first grant port 0.
REQ-032 Port1 rready=0 for 5 cycles after read -> rvalid/rdata held stable, no new port1 read granted; port0 still served each cycle.
REQ-033 With RANGE_CHECK_EN, DEPTH=4096, read byte 0x4000 -> rresp 10, rdata 0; without, returns word 0 contents, rresp 00.
REQ-034 Assert rst low while bvalid pending -> bvalid 0 immediately (async), stays 0 after release until new write.

Source files
------------

// File: rtl/axil_ram_mp.sv
// axil_ram_mp -- multi-port AXI-lite RAM.
//
// N_PORTS AXI-lite slave ports share one single-ported RAM. One RAM access is
// made per cycle. A round-robin arbiter picks the port, starting its search at
// the port after the last one granted. Inside a granted port a pending write
// beats a pending read. AW and W are always accepted together. The B or R
// response appears one cycle after the grant and is held until it is accepted.
//
// Ports (port p occupies slice p of every bus):
//   clk                      single rising-edge clock
//   rst                      asynchronous reset, active low
//   s_awaddr/s_araddr        N_PORTS*ADDR_W  byte addresses
//   s_awvalid/s_wvalid/s_arvalid/s_bready/s_rready   N_PORTS handshake inputs
//   s_wdata/s_wstrb          N_PORTS*DATA_W / N_PORTS*DATA_W/8 write data, byte enables
//   s_awready/s_wready/s_arready/s_bvalid/s_rvalid   N_PORTS handshake outputs
//   s_rdata                  N_PORTS*DATA_W  read data
//   s_bresp/s_rresp          N_PORTS*2  responses (OKAY 2'b00, SLVERR 2'b10)
//
// Build option AXIL_RAM_MP_RANGE_CHECK_EN: when defined, a word index >= DEPTH
// returns SLVERR, a write to it is dropped and read data is zero. When not
// defined, the word index wraps modulo DEPTH (DEPTH must be a power of two)
// and every response is OKAY.
module axil_ram_mp #(
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*ADDR_W-1:0]   s_awaddr,
  input  logic [N_PORTS-1:0]          s_awvalid,
  output logic [N_PORTS-1:0]          s_awready,
  input  logic [N_PORTS*DATA_W-1:0]   s_wdata,
  input  logic [N_PORTS*DATA_W/8-1:0] s_wstrb,
  input  logic [N_PORTS-1:0]          s_wvalid,
  output logic [N_PORTS-1:0]          s_wready,
  output logic [N_PORTS*2-1:0]        s_bresp,
  output logic [N_PORTS-1:0]          s_bvalid,
  input  logic [N_PORTS-1:0]          s_bready,
  input  logic [N_PORTS*ADDR_W-1:0]   s_araddr,
  input  logic [N_PORTS-1:0]          s_arvalid,
  output logic [N_PORTS-1:0]          s_arready,
  output logic [N_PORTS*DATA_W-1:0]   s_rdata,
  output logic [N_PORTS*2-1:0]        s_rresp,
  output logic [N_PORTS-1:0]          s_rvalid,
  input  logic [N_PORTS-1:0]          s_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [N_PORTS-1:0] req_w, req_r, gnt_w, gnt_r;
  logic               gnt_any, gnt_is_wr;
  logic [PTR_W-1:0]   gnt_port, last_reg, cand_p;
  int                 cand;

  logic [ADDR_W-1:0]  acc_addr;
  logic [IDX_W-1:0]   full_idx;
  logic [RAM_AW-1:0]  ram_idx;
  logic               acc_err;
  logic [DATA_W-1:0]  wdata_sel;
  logic [STRB_W-1:0]  wstrb_sel;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  ram_q;

  logic [N_PORTS-1:0]   bvalid_reg, rvalid_reg, fresh_reg;
  logic [N_PORTS*2-1:0] bresp_reg, rresp_reg;
  logic [DATA_W-1:0]    hold_reg [N_PORTS];

  // A response slot counts as free in the cycle its handshake completes,
  // which lets a port be re-granted back to back.
  assign req_w = s_awvalid & s_wvalid & ~(bvalid_reg & ~s_bready);
  assign req_r = s_arvalid & ~(rvalid_reg & ~s_rready);

  // Round-robin search starting at the port after the last grant.
  // rst gates the grant so that no access starts while reset is held.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = '0;
    cand     = 0;
    cand_p   = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = int'(last_reg) + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      cand_p = PTR_W'(cand);
      if (!gnt_any && (req_w[cand_p] || req_r[cand_p])) begin
        gnt_any  = 1'b1;
        gnt_port = cand_p;
      end
    end
    if (!rst) gnt_any = 1'b0;
  end

  assign gnt_is_wr = gnt_any & req_w[gnt_port];

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign gnt_w[gi] = gnt_any && (gnt_port == PTR_W'(gi)) && req_w[gi];
      assign gnt_r[gi] = gnt_any && (gnt_port == PTR_W'(gi)) && !req_w[gi];
      // Data read in the previous cycle comes straight from the RAM output
      // register. Afterwards it is held locally, because another port's read
      // may overwrite ram_q.
      assign s_rdata[gi*DATA_W +: DATA_W] =
        fresh_reg[gi] ? (rresp_reg[gi*2+1] ? '0 : ram_q) : hold_reg[gi];
    end
  endgenerate

  assign s_awready = gnt_w;
  assign s_wready  = gnt_w;
  assign s_arready = gnt_r;
  assign s_bvalid  = bvalid_reg;
  assign s_rvalid  = rvalid_reg;
  assign s_bresp   = bresp_reg;
  assign s_rresp   = rresp_reg;

  assign acc_addr  = gnt_is_wr ? s_awaddr[gnt_port*ADDR_W +: ADDR_W]
                               : s_araddr[gnt_port*ADDR_W +: ADDR_W];
  assign full_idx  = acc_addr[ADDR_W-1:OFF_W];
  assign ram_idx   = full_idx[RAM_AW-1:0];
  assign wdata_sel = s_wdata[gnt_port*DATA_W +: DATA_W];
  assign wstrb_sel = s_wstrb[gnt_port*STRB_W +: STRB_W];

`ifdef AXIL_RAM_MP_RANGE_CHECK_EN
  assign acc_err = (32'(full_idx) >= 32'(DEPTH));
`else
  assign acc_err = 1'b0;
`endif

  // Byte offsets and, when wrapping, the upper index bits are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{s_awaddr, s_araddr, full_idx};

  // RAM: byte-enabled write, registered read, no reset on the contents.
  always_ff @(posedge clk) begin
    if (gnt_is_wr && !acc_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_sel[b]) mem[ram_idx][b*8 +: 8] <= wdata_sel[b*8 +: 8];
      end
    end
    if (gnt_any && !gnt_is_wr) ram_q <= mem[ram_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg   <= PTR_W'(N_PORTS - 1);
      bvalid_reg <= '0;
      rvalid_reg <= '0;
      fresh_reg  <= '0;
      bresp_reg  <= '0;
      rresp_reg  <= '0;
      for (int p = 0; p < N_PORTS; p++) hold_reg[p] <= '0;
    end else begin
      if (gnt_any) last_reg <= gnt_port;
      for (int p = 0; p < N_PORTS; p++) begin
        if (fresh_reg[p]) hold_reg[p] <= s_rdata[p*DATA_W +: DATA_W];
        fresh_reg[p] <= gnt_r[p];
        // A new grant takes priority over the handshake that frees the slot.
        if (gnt_w[p]) begin
          bvalid_reg[p]       <= 1'b1;
          bresp_reg[p*2 +: 2] <= acc_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_bready[p]) begin
          bvalid_reg[p] <= 1'b0;
        end
        if (gnt_r[p]) begin
          rvalid_reg[p]       <= 1'b1;
          rresp_reg[p*2 +: 2] <= acc_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_rready[p]) begin
          rvalid_reg[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_ram_mp.sv
// Bench for axil_ram_mp: directed transactions with literal expectations plus
// a per-cycle reference model (flat memory array, per-port response slots and
// a rotating-priority arbiter) compared against the DUT on every falling edge.
module tb_axil_ram_mp;
  localparam int NP = 2, DW = 32, AW = 16, DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NP*AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [NP-1:0]    s_awvalid = '0, s_wvalid = '0, s_arvalid = '0;
  logic [NP-1:0]    s_bready = '1, s_rready = '1;
  logic [NP*DW-1:0] s_wdata = '0;
  logic [NP*4-1:0]  s_wstrb = '0;
  logic [NP-1:0]    s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [NP*DW-1:0] s_rdata;
  logic [NP*2-1:0]  s_bresp, s_rresp;

  int n_tests = 0;
  int n_fail  = 0;

  axil_ram_mp #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [DEPTH];
  bit          mknown [DEPTH];
  bit [NP-1:0] m_bv = '0, m_rv = '0;
  logic [1:0]  m_bresp [NP];
  logic [1:0]  m_rresp [NP];
  logic [31:0] m_rdata [NP];
  bit          m_rknown [NP];
  int          m_last = NP - 1;

  always @(negedge clk) begin : model
    int g, c, idx;
    bit err;
    bit [NP-1:0] wreq, rreq, exp_w, exp_r;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    if (!rst) begin
      chk("rst_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 64'd0);
      chk("rst_resp", {s_bresp, s_rresp}, 64'd0);
      chk("rst_rdata", s_rdata, 64'd0);
      m_bv = '0; m_rv = '0; m_last = NP - 1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        wreq[p] = s_awvalid[p] && s_wvalid[p] && !(m_bv[p] && !s_bready[p]);
        rreq[p] = s_arvalid[p] && !(m_rv[p] && !s_rready[p]);
      end
      g = -1;
      for (int k = 1; k <= NP; k++) begin
        c = (m_last + k) % NP;
        if (g < 0 && (wreq[c] || rreq[c])) g = c;
      end
      exp_w = '0; exp_r = '0;
      if (g >= 0) begin
        if (wreq[g]) exp_w[g] = 1'b1;
        else         exp_r[g] = 1'b1;
      end
      chk("awready", s_awready, exp_w);
      chk("wready", s_wready, exp_w);
      chk("arready", s_arready, exp_r);
      chk("bvalid", s_bvalid, m_bv);
      chk("rvalid", s_rvalid, m_rv);
      for (int p = 0; p < NP; p++) begin
        if (m_bv[p]) chk("bresp", s_bresp[p*2 +: 2], m_bresp[p]);
        if (m_rv[p]) begin
          chk("rresp", s_rresp[p*2 +: 2], m_rresp[p]);
          if (m_rknown[p]) chk("rdata", s_rdata[p*DW +: DW], m_rdata[p]);
        end
      end
      // advance to the state expected after the coming rising edge
      for (int p = 0; p < NP; p++) begin
        if (m_bv[p] && s_bready[p]) m_bv[p] = 1'b0;
        if (m_rv[p] && s_rready[p]) m_rv[p] = 1'b0;
      end
      if (g >= 0) begin
        m_last = g;
        a = exp_w[g] ? s_awaddr[g*AW +: AW] : s_araddr[g*AW +: AW];
        idx = int'(a) >> 2;
`ifdef AXIL_RAM_MP_RANGE_CHECK_EN
        err = (idx >= DEPTH);
`else
        err = 1'b0;
        idx = idx % DEPTH;
`endif
        if (exp_w[g]) begin
          d  = s_wdata[g*DW +: DW];
          st = s_wstrb[g*4 +: 4];
          if (!err) begin
            for (int b = 0; b < 4; b++) if (st[b]) mmem[idx][b*8 +: 8] = d[b*8 +: 8];
            if (st == 4'hF) mknown[idx] = 1'b1;
          end
          m_bv[g] = 1'b1;
          m_bresp[g] = err ? 2'b10 : 2'b00;
        end else begin
          m_rv[g] = 1'b1;
          m_rresp[g] = err ? 2'b10 : 2'b00;
          m_rdata[g] = err ? 32'h0 : mmem[idx];
          m_rknown[g] = err || mknown[idx];
        end
      end
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic do_write(input int p, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [1:0] resp);
    bit ok;
    @(posedge clk); #1;
    s_awaddr[p*AW +: AW] = a;
    s_wdata[p*DW +: DW]  = d;
    s_wstrb[p*4 +: 4]    = st;
    s_awvalid[p] = 1'b1;
    s_wvalid[p]  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_awready[p]) begin ok = 1'b1; break; end
    end
    chk("w_grant_seen", ok, 1);
    @(posedge clk); #1;
    s_awvalid[p] = 1'b0;
    s_wvalid[p]  = 1'b0;
    chk("b_latency", s_bvalid[p], 1);
    resp = s_bresp[p*2 +: 2];
    $display("[TB] write p%0d addr=0x%04h data=0x%08h strb=0x%0h bresp=%0d", p, a, d, st, resp);
  endtask

  task automatic do_read(input int p, input logic [15:0] a,
                         output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    @(posedge clk); #1;
    s_araddr[p*AW +: AW] = a;
    s_arvalid[p] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_arready[p]) begin ok = 1'b1; break; end
    end
    chk("r_grant_seen", ok, 1);
    @(posedge clk); #1;
    s_arvalid[p] = 1'b0;
    chk("r_latency", s_rvalid[p], 1);
    d    = s_rdata[p*DW +: DW];
    resp = s_rresp[p*2 +: 2];
    $display("[TB] read  p%0d addr=0x%04h rdata=0x%08h rresp=%0d", p, a, d, resp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int g, cnt0, cnt1, held;
    bit phase;

    repeat (3) @(negedge clk);
    chk("reset_bvalid", s_bvalid, 0);
    chk("reset_arready", s_arready, 0);
    @(posedge clk); #1 rst = 1'b1;

    // write then read back, latency 1
    do_write(0, 16'h0010, 32'hDEADBEEF, 4'hF, resp);
    chk("w0010_bresp", resp, 2'b00);
    do_read(0, 16'h0010, data, resp);
    chk("r0010_data", data, 32'hDEADBEEF);
    chk("r0010_rresp", resp, 2'b00);

    // byte strobes
    do_write(1, 16'h0020, 32'hFFFFFFFF, 4'hF, resp);
    do_write(1, 16'h0020, 32'h00000000, 4'h5, resp);
    do_read(1, 16'h0020, data, resp);
    chk("strb5_data", data, 32'hFF00FF00);
    // all-zero strobe still answers but changes nothing; byte offset ignored
    do_write(0, 16'h0020, 32'h12345678, 4'h0, resp);
    chk("strb0_bresp", resp, 2'b00);
    do_read(0, 16'h0022, data, resp);
    chk("strb0_data", data, 32'hFF00FF00);

    // reset while a B response is pending
    s_bready[0] = 1'b0;
    do_write(0, 16'h0030, 32'h0BADF00D, 4'hF, resp);
    #2 rst = 1'b0;
    #1 chk("rst_async_bvalid", s_bvalid[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    s_bready[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bvalid_after_rst", s_bvalid[0], 0);
    end

    // both ports read continuously: grants alternate starting at port 0
    @(posedge clk); #1;
    s_araddr = {16'h0020, 16'h0010};
    s_arvalid = 2'b11;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = (s_arready == 2'b01) ? 0 : (s_arready == 2'b10) ? 1 : -1;
      if (g == 0) cnt0++;
      if (g == 1) cnt1++;
      chk("rr_grant", g, i % 2);
      $display("[TB] rr cycle %0d granted p%0d", i, g);
    end
    @(posedge clk); #1 s_arvalid = 2'b00;
    chk("rr_count0", cnt0, 4);
    chk("rr_count1", cnt1, 4);

    // port 1 stalls its R channel: its response holds, port 0 keeps going
    @(posedge clk); #1;
    s_rready[1] = 1'b0;
    s_arvalid = 2'b11;
    phase = 1'b0; held = 0;
    for (int i = 0; i < 20 && held < 5; i++) begin
      @(negedge clk);
      if (phase) begin
        chk("hold_ar1", s_arready[1], 0);
        chk("hold_ar0", s_arready[0], 1);
        chk("hold_rv1", s_rvalid[1], 1);
        chk("hold_rd1", s_rdata[63:32], 32'hFF00FF00);
        held++;
      end else if (s_arready[1]) begin
        phase = 1'b1;
      end
    end
    chk("hold_cycles", held, 5);
    $display("[TB] stall p1 held %0d cycles", held);
    @(posedge clk); #1;
    s_arvalid = 2'b00;
    s_rready[1] = 1'b1;
    repeat (3) @(negedge clk);

    // address beyond DEPTH words
    do_write(1, 16'h0000, 32'hA5A50001, 4'hF, resp);
    do_read(0, 16'h4000, data, resp);
`ifdef AXIL_RAM_MP_RANGE_CHECK_EN
    chk("oor_rresp", resp, 2'b10);
    chk("oor_rdata", data, 32'h0);
    do_write(0, 16'h4000, 32'h11111111, 4'hF, resp);
    chk("oor_bresp", resp, 2'b10);
    do_read(1, 16'h0000, data, resp);
    chk("oor_no_write", data, 32'hA5A50001);
`else
    chk("wrap_rresp", resp, 2'b00);
    chk("wrap_rdata", data, 32'hA5A50001);
    do_write(0, 16'h4004, 32'h22222222, 4'hF, resp);
    chk("wrap_bresp", resp, 2'b00);
    do_read(1, 16'h0004, data, resp);
    chk("wrap_alias", data, 32'h22222222);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
